// File: rtl/banked_ram_scheduler_pkg.sv
// Shared parameter defaults and types for the banked RAM scheduler and its
// users (banked_ram and friends import the same defaults from here).
package banked_ram_scheduler_pkg;

   localparam int BRS_TAG_W      = 2;
   localparam int BRS_DATA_WIDTH = 16;
   localparam int BRS_ADDR_WIDTH = 13;
   localparam int BRS_CNT_W      = 16;

   typedef enum logic [0:0] {
      PRIO_A = 1'b0,
      PRIO_B = 1'b1
   } prio_e;

endpackage

// File: rtl/banked_ram_scheduler_if.sv
// Requester and RAM-port signal bundle for the banked RAM scheduler.
// The slave modport is the scheduler's view; master is the environment's view.
interface banked_ram_scheduler_if
   import banked_ram_scheduler_pkg::*;
#(
   parameter int DATA_WIDTH = BRS_DATA_WIDTH,
   parameter int ADDR_WIDTH = BRS_ADDR_WIDTH
);
   logic                  req_valid_a, req_valid_b;
   logic                  req_ready_a, req_ready_b;
   logic                  req_wr_a, req_wr_b;
   logic [ADDR_WIDTH-1:0] req_addr_a, req_addr_b;
   logic [DATA_WIDTH-1:0] req_wdata_a, req_wdata_b;
   logic                  rsp_valid_a, rsp_valid_b;
   logic [DATA_WIDTH-1:0] rsp_data_a, rsp_data_b;

   logic                  s_read_req_a, s_read_req_b;
   logic [ADDR_WIDTH-1:0] s_read_addr_a, s_read_addr_b;
   logic [DATA_WIDTH-1:0] s_read_data_a, s_read_data_b;
   logic                  s_write_req_a, s_write_req_b;
   logic [ADDR_WIDTH-1:0] s_write_addr_a, s_write_addr_b;
   logic [DATA_WIDTH-1:0] s_write_data_a, s_write_data_b;

   modport slave (
      input  req_valid_a, req_valid_b, req_wr_a, req_wr_b,
      input  req_addr_a, req_addr_b, req_wdata_a, req_wdata_b,
      input  s_read_data_a, s_read_data_b,
      output req_ready_a, req_ready_b, rsp_valid_a, rsp_valid_b,
      output rsp_data_a, rsp_data_b,
      output s_read_req_a, s_read_req_b, s_read_addr_a, s_read_addr_b,
      output s_write_req_a, s_write_req_b, s_write_addr_a, s_write_addr_b,
      output s_write_data_a, s_write_data_b
   );

   modport master (
      output req_valid_a, req_valid_b, req_wr_a, req_wr_b,
      output req_addr_a, req_addr_b, req_wdata_a, req_wdata_b,
      output s_read_data_a, s_read_data_b,
      input  req_ready_a, req_ready_b, rsp_valid_a, rsp_valid_b,
      input  rsp_data_a, rsp_data_b,
      input  s_read_req_a, s_read_req_b, s_read_addr_a, s_read_addr_b,
      input  s_write_req_a, s_write_req_b, s_write_addr_a, s_write_addr_b,
      input  s_write_data_a, s_write_data_b
   );
endinterface

// File: rtl/banked_ram_scheduler_rr_arbiter_2.sv
// Two-way round-robin arbiter: grants everything when there is no conflict,
// and on a conflict grants the priority holder and hands priority over.
module rr_arbiter_2
   import banked_ram_scheduler_pkg::*;
(
   input  logic clk,
   input  logic reset,
   input  logic req_a_i,
   input  logic req_b_i,
   input  logic conflict_i,
   output logic grant_a_o,
   output logic grant_b_o,
   output logic prio_b_o
);
   prio_e prio_q, prio_d;

   // Grant decode and priority hand-over; reset masks every grant.
   always_comb begin
      prio_d    = prio_q;
      grant_a_o = 1'b0;
      grant_b_o = 1'b0;
      if (reset) begin
         grant_a_o = 1'b0;
         grant_b_o = 1'b0;
      end else if (conflict_i) begin
         grant_a_o = (prio_q == PRIO_A);
         grant_b_o = (prio_q == PRIO_B);
         prio_d    = (prio_q == PRIO_A) ? PRIO_B : PRIO_A;
      end else begin
         grant_a_o = req_a_i;
         grant_b_o = req_b_i;
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         prio_q <= PRIO_A;
      end else begin
         prio_q <= prio_d;
      end
   end

   assign prio_b_o = (prio_q == PRIO_B);

endmodule

// File: rtl/banked_ram_scheduler.sv
// Two-requester scheduler in front of a dual-port banked RAM; same-bank,
// same-direction collisions are serialized round-robin and counted.
module banked_ram_scheduler
   import banked_ram_scheduler_pkg::*;
#(
   parameter int TAG_W      = BRS_TAG_W,
   parameter int DATA_WIDTH = BRS_DATA_WIDTH,
   parameter int ADDR_WIDTH = BRS_ADDR_WIDTH,
   parameter int CNT_W      = BRS_CNT_W
) (
   input  logic                 clk,
   input  logic                 reset,
   banked_ram_scheduler_if.slave bus,
   output logic [CNT_W-1:0]     conflict_count,
   output logic                 prio_b
);
   logic [TAG_W-1:0] tag_a_s, tag_b_s;
   logic             conflict_s;
   logic             grant_a_s, grant_b_s;
   logic             rsp_valid_a_q, rsp_valid_a_d;
   logic             rsp_valid_b_q, rsp_valid_b_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;

   assign tag_a_s    = bus.req_addr_a[ADDR_WIDTH-1 -: TAG_W];
   assign tag_b_s    = bus.req_addr_b[ADDR_WIDTH-1 -: TAG_W];
   // A read and a write never collide: the RAM has separate read and write ports.
   assign conflict_s = bus.req_valid_a & bus.req_valid_b &
                       (bus.req_wr_a == bus.req_wr_b) & (tag_a_s == tag_b_s);

   rr_arbiter_2 u_arb (
      .clk        (clk),
      .reset      (reset),
      .req_a_i    (bus.req_valid_a),
      .req_b_i    (bus.req_valid_b),
      .conflict_i (conflict_s),
      .grant_a_o  (grant_a_s),
      .grant_b_o  (grant_b_s),
      .prio_b_o   (prio_b)
   );

   assign bus.req_ready_a    = grant_a_s;
   assign bus.req_ready_b    = grant_b_s;
   assign bus.s_read_req_a   = grant_a_s & ~bus.req_wr_a;
   assign bus.s_read_req_b   = grant_b_s & ~bus.req_wr_b;
   assign bus.s_write_req_a  = grant_a_s & bus.req_wr_a;
   assign bus.s_write_req_b  = grant_b_s & bus.req_wr_b;
   assign bus.s_read_addr_a  = bus.req_addr_a;
   assign bus.s_read_addr_b  = bus.req_addr_b;
   assign bus.s_write_addr_a = bus.req_addr_a;
   assign bus.s_write_addr_b = bus.req_addr_b;
   assign bus.s_write_data_a = bus.req_wdata_a;
   assign bus.s_write_data_b = bus.req_wdata_b;
   assign bus.rsp_data_a     = DATA_WIDTH'(bus.s_read_data_a);
   assign bus.rsp_data_b     = DATA_WIDTH'(bus.s_read_data_b);
   assign bus.rsp_valid_a    = rsp_valid_a_q;
   assign bus.rsp_valid_b    = rsp_valid_b_q;
   assign conflict_count     = cnt_q;

   // Next-state for response valids and the saturating conflict counter.
   always_comb begin
      rsp_valid_a_d = bus.s_read_req_a;
      rsp_valid_b_d = bus.s_read_req_b;
      cnt_d         = cnt_q;
      if (conflict_s && (cnt_q != {CNT_W{1'b1}})) begin
         cnt_d = cnt_q + CNT_W'(1);
      end else begin
         cnt_d = cnt_q;
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         rsp_valid_a_q <= 1'b0;
         rsp_valid_b_q <= 1'b0;
         cnt_q         <= {CNT_W{1'b0}};
      end else begin
         rsp_valid_a_q <= rsp_valid_a_d;
         rsp_valid_b_q <= rsp_valid_b_d;
         cnt_q         <= cnt_d;
      end
   end

endmodule

// File: tb/tb_banked_ram_scheduler.sv
// Directed bench for banked_ram_scheduler with a behavioural dual-port RAM
// (registered read, read-before-write) and a 4-bit-counter instance.
module tb_banked_ram_scheduler;
   logic        clk;
   logic        reset;
   logic [15:0] cnt;
   logic [3:0]  cnt4;
   logic        prio_b, prio4;
   logic [15:0] rd_a, rd_b;
   logic [15:0] mem [int];
   int          checks = 0;
   int          errors = 0;

   banked_ram_scheduler_if #(.DATA_WIDTH(16), .ADDR_WIDTH(13)) bus ();
   banked_ram_scheduler_if #(.DATA_WIDTH(16), .ADDR_WIDTH(13)) bus4 ();

   banked_ram_scheduler #(.TAG_W(2), .DATA_WIDTH(16), .ADDR_WIDTH(13), .CNT_W(16)) dut (
      .clk(clk), .reset(reset), .bus(bus), .conflict_count(cnt), .prio_b(prio_b));
   banked_ram_scheduler #(.TAG_W(2), .DATA_WIDTH(16), .ADDR_WIDTH(13), .CNT_W(4)) dut4 (
      .clk(clk), .reset(reset), .bus(bus4), .conflict_count(cnt4), .prio_b(prio4));

   initial clk = 1'b0;
   always #5 clk = ~clk;

   function automatic logic [15:0] pat(input logic [12:0] a);
      pat = ({3'b000, a} * 16'd3) ^ 16'h5A5A;
   endfunction

   function automatic logic [15:0] mem_rd(input logic [12:0] a);
      if (mem.exists(int'(a))) mem_rd = mem[int'(a)];
      else mem_rd = pat(a);
   endfunction

   // RAM model: reads sample old contents before same-edge writes land
   always @(posedge clk) begin
      if (bus.s_read_req_a) rd_a <= mem_rd(bus.s_read_addr_a);
      if (bus.s_read_req_b) rd_b <= mem_rd(bus.s_read_addr_b);
      if (bus.s_write_req_a) mem[int'(bus.s_write_addr_a)] = bus.s_write_data_a;
      if (bus.s_write_req_b) mem[int'(bus.s_write_addr_b)] = bus.s_write_data_b;
   end
   assign bus.s_read_data_a  = rd_a;
   assign bus.s_read_data_b  = rd_b;
   assign bus4.s_read_data_a = 16'h0000;
   assign bus4.s_read_data_b = 16'h0000;

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic idle();
      bus.req_valid_a = 1'b0; bus.req_wr_a = 1'b0; bus.req_addr_a = 13'h0; bus.req_wdata_a = 16'h0;
      bus.req_valid_b = 1'b0; bus.req_wr_b = 1'b0; bus.req_addr_b = 13'h0; bus.req_wdata_b = 16'h0;
   endtask

   task automatic idle4();
      bus4.req_valid_a = 1'b0; bus4.req_wr_a = 1'b0; bus4.req_addr_a = 13'h0; bus4.req_wdata_a = 16'h0;
      bus4.req_valid_b = 1'b0; bus4.req_wr_b = 1'b0; bus4.req_addr_b = 13'h0; bus4.req_wdata_b = 16'h0;
   endtask

   task automatic do_reset();
      reset = 1'b1;
      step();
      reset = 1'b0;
   endtask

   task automatic test_reset();
      reset = 1'b1;
      bus.req_valid_a = 1'b1; bus.req_wr_a = 1'b0; bus.req_addr_a = 13'h0005;
      bus.req_valid_b = 1'b1; bus.req_wr_b = 1'b1; bus.req_addr_b = 13'h0805;
      #1;
      checks++; if (bus.req_ready_a !== 1'b0) begin errors++; $display("FAIL rst_ready_a: got %b expected 0", bus.req_ready_a); end
      checks++; if (bus.req_ready_b !== 1'b0) begin errors++; $display("FAIL rst_ready_b: got %b expected 0", bus.req_ready_b); end
      checks++; if ({bus.s_read_req_a, bus.s_write_req_b} !== 2'b00) begin errors++; $display("FAIL rst_strobes: got %b expected 00", {bus.s_read_req_a, bus.s_write_req_b}); end
      step();
      checks++; if ({bus.rsp_valid_a, bus.rsp_valid_b, prio_b} !== 3'b000) begin errors++; $display("FAIL rst_state: got %b expected 000", {bus.rsp_valid_a, bus.rsp_valid_b, prio_b}); end
      checks++; if (cnt !== 16'h0000) begin errors++; $display("FAIL rst_count: got %h expected 0000", cnt); end
      // a read granted in the cycle just before reset must not leave a response
      reset = 1'b0;
      bus.req_valid_b = 1'b0;
      step();
      checks++; if (bus.rsp_valid_a !== 1'b1) begin errors++; $display("FAIL pre_rst_read: got %b expected 1", bus.rsp_valid_a); end
      idle();
      reset = 1'b1;
      step();
      checks++; if (bus.rsp_valid_a !== 1'b0) begin errors++; $display("FAIL rst_kills_rsp: got %b expected 0", bus.rsp_valid_a); end
      reset = 1'b0;
   endtask

   task automatic test_parallel_reads();
      do_reset();
      bus.req_valid_a = 1'b1; bus.req_wr_a = 1'b0; bus.req_addr_a = 13'h0005;
      bus.req_valid_b = 1'b1; bus.req_wr_b = 1'b0; bus.req_addr_b = 13'h0805;
      #1;
      checks++; if ({bus.req_ready_a, bus.req_ready_b} !== 2'b11) begin errors++; $display("FAIL par_ready: got %b expected 11", {bus.req_ready_a, bus.req_ready_b}); end
      step();
      idle();
      checks++; if ({bus.rsp_valid_a, bus.rsp_valid_b} !== 2'b11) begin errors++; $display("FAIL par_rsp_valid: got %b expected 11", {bus.rsp_valid_a, bus.rsp_valid_b}); end
      checks++; if (bus.rsp_data_a !== pat(13'h0005)) begin errors++; $display("FAIL par_data_a: got %h expected %h", bus.rsp_data_a, pat(13'h0005)); end
      checks++; if (bus.rsp_data_b !== pat(13'h0805)) begin errors++; $display("FAIL par_data_b: got %h expected %h", bus.rsp_data_b, pat(13'h0805)); end
      checks++; if (cnt !== 16'h0000) begin errors++; $display("FAIL par_count: got %h expected 0000", cnt); end
      step();
      checks++; if ({bus.rsp_valid_a, bus.rsp_valid_b} !== 2'b00) begin errors++; $display("FAIL par_rsp_drop: got %b expected 00", {bus.rsp_valid_a, bus.rsp_valid_b}); end
   endtask

   task automatic test_conflict_reads();
      do_reset();
      bus.req_valid_a = 1'b1; bus.req_wr_a = 1'b0; bus.req_addr_a = 13'h0010;
      bus.req_valid_b = 1'b1; bus.req_wr_b = 1'b0; bus.req_addr_b = 13'h0011;
      #1;
      checks++; if ({bus.req_ready_a, bus.req_ready_b} !== 2'b10) begin errors++; $display("FAIL cf_c1_ready: got %b expected 10", {bus.req_ready_a, bus.req_ready_b}); end
      checks++; if ({bus.s_read_req_a, bus.s_read_req_b} !== 2'b10) begin errors++; $display("FAIL cf_c1_strobe: got %b expected 10", {bus.s_read_req_a, bus.s_read_req_b}); end
      step();
      bus.req_valid_a = 1'b0;
      checks++; if (prio_b !== 1'b1) begin errors++; $display("FAIL cf_prio: got %b expected 1", prio_b); end
      checks++; if (bus.rsp_data_a !== pat(13'h0010) || bus.rsp_valid_a !== 1'b1) begin errors++; $display("FAIL cf_rsp_a: got %b/%h expected 1/%h", bus.rsp_valid_a, bus.rsp_data_a, pat(13'h0010)); end
      #1;
      checks++; if (bus.req_ready_b !== 1'b1) begin errors++; $display("FAIL cf_c2_ready_b: got %b expected 1", bus.req_ready_b); end
      step();
      idle();
      checks++; if (bus.rsp_data_b !== pat(13'h0011) || bus.rsp_valid_b !== 1'b1) begin errors++; $display("FAIL cf_rsp_b: got %b/%h expected 1/%h", bus.rsp_valid_b, bus.rsp_data_b, pat(13'h0011)); end
      checks++; if (cnt !== 16'd1) begin errors++; $display("FAIL cf_count: got %0d expected 1", cnt); end
      checks++; if (prio_b !== 1'b1) begin errors++; $display("FAIL cf_prio_hold: got %b expected 1", prio_b); end
   endtask

   task automatic test_write_serialize();
      do_reset();
      bus.req_valid_a = 1'b1; bus.req_wr_a = 1'b1; bus.req_addr_a = 13'h1000; bus.req_wdata_a = 16'hBEEF;
      bus.req_valid_b = 1'b1; bus.req_wr_b = 1'b1; bus.req_addr_b = 13'h1004; bus.req_wdata_b = 16'h1234;
      #1;
      checks++; if ({bus.req_ready_a, bus.req_ready_b, bus.s_write_req_a, bus.s_write_req_b} !== 4'b1010) begin errors++; $display("FAIL wr_c1: got %b expected 1010", {bus.req_ready_a, bus.req_ready_b, bus.s_write_req_a, bus.s_write_req_b}); end
      checks++; if ({bus.s_read_req_a, bus.s_read_req_b} !== 2'b00) begin errors++; $display("FAIL wr_no_read: got %b expected 00", {bus.s_read_req_a, bus.s_read_req_b}); end
      step();
      bus.req_valid_a = 1'b0;
      #1;
      checks++; if ({bus.req_ready_b, bus.s_write_req_b} !== 2'b11) begin errors++; $display("FAIL wr_c2: got %b expected 11", {bus.req_ready_b, bus.s_write_req_b}); end
      checks++; if (bus.s_write_addr_b !== 13'h1004 || bus.s_write_data_b !== 16'h1234) begin errors++; $display("FAIL wr_c2_bus: got %h/%h expected 1004/1234", bus.s_write_addr_b, bus.s_write_data_b); end
      step();
      idle();
      bus.req_valid_a = 1'b1; bus.req_addr_a = 13'h1000;
      step();
      bus.req_addr_a = 13'h1004;
      checks++; if (bus.rsp_data_a !== 16'hBEEF) begin errors++; $display("FAIL wr_rb_a: got %h expected beef", bus.rsp_data_a); end
      step();
      idle();
      checks++; if (bus.rsp_data_a !== 16'h1234) begin errors++; $display("FAIL wr_rb_b: got %h expected 1234", bus.rsp_data_a); end
      checks++; if (cnt !== 16'd1) begin errors++; $display("FAIL wr_count: got %0d expected 1", cnt); end
   endtask

   task automatic test_read_write_same_addr();
      do_reset();
      bus.req_valid_a = 1'b1; bus.req_wr_a = 1'b1; bus.req_addr_a = 13'h0020; bus.req_wdata_a = 16'hAAAA;
      bus.req_valid_b = 1'b1; bus.req_wr_b = 1'b0; bus.req_addr_b = 13'h0020;
      #1;
      checks++; if ({bus.req_ready_a, bus.req_ready_b} !== 2'b11) begin errors++; $display("FAIL rw_ready: got %b expected 11", {bus.req_ready_a, bus.req_ready_b}); end
      step();
      bus.req_valid_a = 1'b0;
      checks++; if (bus.rsp_valid_b !== 1'b1 || bus.rsp_data_b !== pat(13'h0020)) begin errors++; $display("FAIL rw_old_data: got %b/%h expected 1/%h", bus.rsp_valid_b, bus.rsp_data_b, pat(13'h0020)); end
      checks++; if (cnt !== 16'd0) begin errors++; $display("FAIL rw_count: got %0d expected 0", cnt); end
      step();
      idle();
      checks++; if (bus.rsp_data_b !== 16'hAAAA) begin errors++; $display("FAIL rw_new_data: got %h expected aaaa", bus.rsp_data_b); end
   endtask

   task automatic test_back_to_back();
      int resp_a = 0;
      int resp_b = 0;
      do_reset();
      bus.req_valid_a = 1'b1; bus.req_wr_a = 1'b0; bus.req_addr_a = 13'h0040;
      bus.req_valid_b = 1'b1; bus.req_wr_b = 1'b0; bus.req_addr_b = 13'h0041;
      for (int i = 0; i < 20; i++) begin
         #1;
         checks++;
         if ({bus.req_ready_a, bus.req_ready_b} !== ((i % 2 == 0) ? 2'b10 : 2'b01)) begin
            errors++;
            $display("FAIL b2b_grant[%0d]: got %b expected %b", i, {bus.req_ready_a, bus.req_ready_b}, (i % 2 == 0) ? 2'b10 : 2'b01);
         end
         step();
         if (bus.rsp_valid_a) resp_a++;
         if (bus.rsp_valid_b) resp_b++;
      end
      idle();
      step();
      if (bus.rsp_valid_a) resp_a++;
      if (bus.rsp_valid_b) resp_b++;
      checks++; if (resp_a != 10 || resp_b != 10) begin errors++; $display("FAIL b2b_responses: got %0d/%0d expected 10/10", resp_a, resp_b); end
      checks++; if (cnt !== 16'd20) begin errors++; $display("FAIL b2b_count: got %0d expected 20", cnt); end
   endtask

   task automatic test_saturate();
      do_reset();
      bus4.req_valid_a = 1'b1; bus4.req_wr_a = 1'b0; bus4.req_addr_a = 13'h0010;
      bus4.req_valid_b = 1'b1; bus4.req_wr_b = 1'b0; bus4.req_addr_b = 13'h0011;
      for (int i = 0; i < 16; i++) step();
      checks++; if (cnt4 !== 4'd15) begin errors++; $display("FAIL sat_reach: got %0d expected 15", cnt4); end
      step();
      checks++; if (cnt4 !== 4'd15) begin errors++; $display("FAIL sat_hold: got %0d expected 15", cnt4); end
      reset = 1'b1;
      #1;
      checks++; if ({bus4.req_ready_a, bus4.req_ready_b, bus4.s_read_req_a, bus4.s_read_req_b} !== 4'b0000) begin errors++; $display("FAIL sat_rst_comb: got %b expected 0000", {bus4.req_ready_a, bus4.req_ready_b, bus4.s_read_req_a, bus4.s_read_req_b}); end
      step();
      checks++; if (cnt4 !== 4'd0) begin errors++; $display("FAIL sat_rst_count: got %0d expected 0", cnt4); end
      checks++; if ({bus4.rsp_valid_a, bus4.rsp_valid_b, prio4} !== 3'b000) begin errors++; $display("FAIL sat_rst_state: got %b expected 000", {bus4.rsp_valid_a, bus4.rsp_valid_b, prio4}); end
      reset = 1'b0;
      idle4();
      step();
   endtask

   initial begin
      reset = 1'b1;
      idle();
      idle4();
      test_reset();
      test_parallel_reads();
      test_conflict_reads();
      test_write_serialize();
      test_read_write_same_addr();
      test_back_to_back();
      test_saturate();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/banked_ram_scheduler.md
BANKED_RAM_SCHEDULER -- requirements
Module: banked_ram_scheduler

Interface
REQ-001 SHALL have parameter TAG_W, default 2, bank-select bits (the MSBs of the address).
REQ-002 SHALL have parameter DATA_WIDTH, default 16, word width.
REQ-003 SHALL have parameter ADDR_WIDTH, default 13, word address width including the tag.
REQ-004 SHALL have parameter CNT_W, default 16, conflict-counter width.
REQ-005 SHALL use one clock, clk; reset is synchronous and active-high, named reset.
REQ-006 clk  input  1  clock.
REQ-007 reset  input  1  synchronous active-high reset.
REQ-008 For each requester x in {a,b}, SHALL have the following ports:
- req_valid_x  input  1  request valid.
- req_ready_x  output  1  request accepted this cycle.
- req_wr_x  input  1  1=write, 0=read.
- req_addr_x  input  ADDR_WIDTH  word address.
- req_wdata_x  input  DATA_WIDTH  write data.
- rsp_valid_x  output  1  read data valid.
- rsp_data_x  output  DATA_WIDTH  read data.
REQ-009 For each RAM port x in {a,b}, SHALL have the following ports:
- s_read_req_x  output  1  RAM read strobe.
- s_read_addr_x  output  ADDR_WIDTH  RAM read address.
- s_read_data_x  input  DATA_WIDTH  RAM read data.
- s_write_req_x  output  1  RAM write strobe.
- s_write_addr_x  output  ADDR_WIDTH  RAM write address.
- s_write_data_x  output  DATA_WIDTH  RAM write data.
REQ-010 conflict_count  output  CNT_W  saturating count of conflict cycles.
REQ-011 prio_b  output  1  current priority holder (0=a, 1=b).

Function
REQ-012 Requester a SHALL map to RAM port a, and requester b to RAM port b; addresses and data SHALL pass through unmodified.
REQ-013 Tag SHALL be addr[ADDR_WIDTH-1 -: TAG_W].
REQ-014 Conflict SHALL mean: both req_valid high, equal req_wr, equal tags; read/write pairs never conflict.
REQ-015 With no conflict, every valid request SHALL be granted: req_ready_x = req_valid_x, combinational, same cycle.
REQ-016 On conflict, only the priority holder SHALL be granted; the loser SHALL see req_ready low and must hold its request.
REQ-017 prio_b SHALL toggle at the clock edge ending each conflict cycle, and be unchanged otherwise; this guarantees the loser wins the next conflict.
REQ-018 RAM strobes SHALL be asserted only for granted requests:
- s_read_req_x = grant_x & ~req_wr_x.
- s_write_req_x = grant_x & req_wr_x.
REQ-019 Read latency SHALL be 1: rsp_valid_x SHALL be registered, high exactly the cycle after a granted read, low otherwise.
REQ-020 rsp_data_x SHALL equal s_read_data_x combinationally.
REQ-021 No read forwarding: a read and a write to the same address in the same cycle SHALL return pre-write data.
REQ-022 conflict_count SHALL increment by 1 per conflict cycle and saturate at all-ones without wrapping.
REQ-023 Requests with req_valid low SHALL never produce RAM strobes, regardless of req_wr, addr or data.

Reset
REQ-024 While reset is high, req_ready_x and all RAM strobes SHALL be 0.
REQ-025 Reset SHALL clear rsp_valid_x=0, prio_b=0 and conflict_count=0 at the next edge.
REQ-026 A read granted in the cycle before reset rises SHALL NOT produce rsp_valid after the reset edge.

Structure
REQ-027 Default values of TAG_W, DATA_WIDTH and ADDR_WIDTH SHALL live in the shared accelerator parameter include, used with banked_ram.
REQ-028 A single sub-module, rr_arbiter_2, SHALL hold the priority flop and grant logic; it SHALL be instantiated once per op type, or shared with conflict-only toggling.

Verification
REQ-029 Read a 0x0005 and read b 0x0805 (tags 0 and 1) in the same cycle -> both ready; next cycle both rsp_valid high with correct data; conflict_count stays 0.
REQ-030 Read a 0x0010 and read b 0x0011 (both tag 0) held 2 cycles, from reset ->
- Cycle 1: a granted, prio_b becomes 1.
- Cycle 2: b granted.
- conflict_count = 1.
REQ-031 Write a 0x1000=0xBEEF and write b 0x1004=0x1234 (same tag) -> writes serialized over 2 cycles; readback returns both values.
REQ-032 Write a 0x0020=0xAAAA and read b 0x0020 in the same cycle -> no conflict; rsp_data_b is old data; a later read returns 0xAAAA.
REQ-033 Continuous same-bank reads from both requesters for 20 cycles -> grants alternate a,b,a,...; each requester receives 10 responses; conflict_count = 20.
REQ-034 Preload conflict_count to all-ones via forced conflicts (CNT_W=4, 16 conflicts) -> count holds 15; reset asserted mid-burst -> all outputs 0 next cycle.
